// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, CB prefix byte, interrupt
// vector base and IRQ bit positions (also consumed by the decode lookup).
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_CB_FETCH = 3'd1,
        ST_EXEC     = 3'd2,
        ST_HALT     = 3'd3,
        ST_INT      = 3'd4
    } seq_state_e;

    localparam int unsigned IRQ_W     = 5;
    localparam int unsigned IRQ_IDX_W = 3;

    localparam logic [7:0] CB_PREFIX    = 8'hCB;
    localparam logic [7:0] IRQ_VEC_BASE = 8'h40;

    localparam int unsigned IRQ_VBLANK   = 0;
    localparam int unsigned IRQ_LCD_STAT = 1;
    localparam int unsigned IRQ_TIMER    = 2;
    localparam int unsigned IRQ_SERIAL   = 3;
    localparam int unsigned IRQ_JOYPAD   = 4;

    // Restart address for interrupt source idx: 0x40 + 8*idx.
    function automatic logic [7:0] irq_vector(input logic [IRQ_IDX_W-1:0] idx);
        return IRQ_VEC_BASE + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/cpu_sequencer_irq_prio.sv
// Lowest-set-bit priority encoder over the pending interrupt lines.
module cpu_sequencer_irq_prio
    import cpu_sequencer_pkg::*;
(
    input  logic [IRQ_W-1:0]     i_pend,
    output logic                 o_any_c,
    output logic [IRQ_IDX_W-1:0] o_idx_c,
    output logic [IRQ_W-1:0]     o_onehot_c
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        o_idx_c = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_idx_c = IRQ_IDX_W'(i);
            end
        end
    end

    assign o_onehot_c = i_pend & (~i_pend + IRQ_W'(1));
    assign o_any_c    = |i_pend;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: T-state/M-cycle timing, opcode fetch (incl. CB
// prefix), multi-cycle execute, HALT, IME/EI delay and interrupt dispatch.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned INT_MCYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           bus_rdata,
    input  logic [2:0]           op_mcycles,
    input  logic                 cond_fail,
    input  logic                 ei_req,
    input  logic                 di_req,
    input  logic                 halt_req,
    input  logic [IRQ_W-1:0]     int_pend,
    output logic [7:0]           opcode,
    output logic                 cb_prefix,
    output logic [1:0]           tstate,
    output logic [2:0]           mcycle,
    output logic                 fetch,
    output logic [IRQ_W-1:0]     int_ack,
    output logic [7:0]           int_vector,
    output logic                 ime,
    output logic                 halted
);

    localparam logic [2:0] INT_LAST = 3'(INT_MCYCLES - 1);
    localparam logic [2:0] INT_PRE  = 3'(INT_MCYCLES - 2);
    localparam logic       INT_ONE  = (INT_MCYCLES == 1);

    seq_state_e           r_state;
    logic [1:0]           r_tstate;
    logic [2:0]           r_mcycle;
    logic [7:0]           r_opcode;
    logic                 r_cb_prefix;
    logic                 r_fetch;
    logic                 r_ime;
    logic                 r_ei_pend;
    logic                 r_halted;
    logic [IRQ_W-1:0]     r_int_ack;
    logic [7:0]           r_int_vector;
    logic [IRQ_IDX_W-1:0] r_irq_idx;
    logic [IRQ_W-1:0]     r_irq_onehot;

    logic                 w_prio_any;
    logic [IRQ_IDX_W-1:0] w_prio_idx;
    logic [IRQ_W-1:0]     w_prio_onehot;

    logic                 w_tstate_last;
    logic                 w_cb_cnt;
    logic [3:0]           w_steps;
    logic [3:0]           w_need;
    logic                 w_last;
    logic                 w_boundary;
    logic                 w_ime_eff;
    logic                 w_dispatch;
    logic                 w_halt_int;
    logic                 w_int_entry;
    seq_state_e           w_bnd_state;
    logic                 w_ack_go;
    logic [IRQ_IDX_W-1:0] w_ack_idx;
    logic [IRQ_W-1:0]     w_ack_onehot;

    cpu_sequencer_irq_prio u_irq_prio (
        .i_pend     (int_pend),
        .o_any_c    (w_prio_any),
        .o_idx_c    (w_prio_idx),
        .o_onehot_c (w_prio_onehot)
    );

    assign w_tstate_last = (r_tstate == 2'd3);

    // A CB-prefixed instruction's count excludes the prefix M-cycle.
    assign w_cb_cnt = (r_state == ST_CB_FETCH) || ((r_state == ST_EXEC) && r_cb_prefix);
    assign w_steps  = {1'b0, r_mcycle} + 4'd1 - {3'b000, w_cb_cnt};
    assign w_need   = (op_mcycles == 3'd0) ? 4'd1 : {1'b0, op_mcycles};
    assign w_last   = cond_fail || (w_steps >= w_need);

    assign w_boundary = w_tstate_last && w_last &&
                        ((r_state == ST_EXEC) || (r_state == ST_CB_FETCH) ||
                         ((r_state == ST_FETCH) && (bus_rdata != CB_PREFIX)));

    // A pending EI counts at the boundary of the instruction that follows it.
    assign w_ime_eff   = (r_ime || r_ei_pend) && !di_req;
    assign w_dispatch  = w_boundary && w_ime_eff && w_prio_any;
    assign w_halt_int  = w_tstate_last && (r_state == ST_HALT) && w_prio_any && r_ime;
    assign w_int_entry = w_dispatch || w_halt_int;
    assign w_bnd_state = w_dispatch ? ST_INT : (halt_req ? ST_HALT : ST_FETCH);

    // Acknowledge is launched on the edge that starts the final INT M-cycle.
    assign w_ack_go = (w_int_entry && INT_ONE) ||
                      (w_tstate_last && (r_state == ST_INT) && !INT_ONE && (r_mcycle == INT_PRE));
    assign w_ack_idx    = (r_state == ST_INT) ? r_irq_idx    : w_prio_idx;
    assign w_ack_onehot = (r_state == ST_INT) ? r_irq_onehot : w_prio_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_tstate     <= '0;
            r_mcycle     <= '0;
            r_opcode     <= '0;
            r_cb_prefix  <= 1'b0;
            r_fetch      <= 1'b1;
            r_ime        <= 1'b0;
            r_ei_pend    <= 1'b0;
            r_halted     <= 1'b0;
            r_int_ack    <= '0;
            r_int_vector <= '0;
            r_irq_idx    <= '0;
            r_irq_onehot <= '0;
        end else begin
            r_tstate  <= r_tstate + 2'd1;
            r_int_ack <= '0;
            if (w_ack_go) begin
                r_int_ack    <= w_ack_onehot;
                r_int_vector <= irq_vector(w_ack_idx);
            end
            if (w_tstate_last) begin
                if (w_boundary) begin
                    r_ime     <= w_ime_eff;
                    r_ei_pend <= ei_req && !di_req;
                end
                if (w_int_entry) begin
                    r_ime        <= 1'b0;
                    r_ei_pend    <= 1'b0;
                    r_irq_idx    <= w_prio_idx;
                    r_irq_onehot <= w_prio_onehot;
                end
                case (r_state)
                    ST_FETCH: begin
                        r_opcode    <= bus_rdata;
                        r_cb_prefix <= 1'b0;
                        if (bus_rdata == CB_PREFIX) begin
                            r_state  <= ST_CB_FETCH;
                            r_mcycle <= 3'd1;
                        end else if (!w_last) begin
                            r_state  <= ST_EXEC;
                            r_mcycle <= 3'd1;
                            r_fetch  <= 1'b0;
                        end
                    end
                    ST_CB_FETCH: begin
                        r_opcode    <= bus_rdata;
                        r_cb_prefix <= 1'b1;
                        if (!w_last) begin
                            r_state  <= ST_EXEC;
                            r_mcycle <= r_mcycle + 3'd1;
                            r_fetch  <= 1'b0;
                        end
                    end
                    ST_EXEC: begin
                        if (!w_last) begin
                            r_mcycle <= r_mcycle + 3'd1;
                        end
                    end
                    ST_HALT: begin
                        if (w_prio_any) begin
                            r_halted <= 1'b0;
                            r_mcycle <= '0;
                            if (r_ime) begin
                                r_state <= ST_INT;
                                r_fetch <= 1'b0;
                            end else begin
                                r_state <= ST_FETCH;
                                r_fetch <= 1'b1;
                            end
                        end
                    end
                    ST_INT: begin
                        if (r_mcycle == INT_LAST) begin
                            r_state  <= ST_FETCH;
                            r_mcycle <= '0;
                            r_fetch  <= 1'b1;
                        end else begin
                            r_mcycle <= r_mcycle + 3'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_FETCH;
                        r_mcycle <= '0;
                        r_fetch  <= 1'b1;
                    end
                endcase
                // Instruction boundary overrides the per-state advance above.
                if (w_boundary) begin
                    r_state  <= w_bnd_state;
                    r_mcycle <= '0;
                    r_fetch  <= (w_bnd_state == ST_FETCH);
                    r_halted <= (w_bnd_state == ST_HALT);
                end
            end
        end
    end

    assign opcode     = r_opcode;
    assign cb_prefix  = r_cb_prefix;
    assign tstate     = r_tstate;
    assign mcycle     = r_mcycle;
    assign fetch      = r_fetch;
    assign int_ack    = r_int_ack;
    assign int_vector = r_int_vector;
    assign ime        = r_ime;
    assign halted     = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_rdata = 8'h00;
    logic [2:0] op_mcycles = 3'd1;
    logic       cond_fail = 1'b0;
    logic       ei_req = 1'b0;
    logic       di_req = 1'b0;
    logic       halt_req = 1'b0;
    logic [4:0] int_pend = 5'b0;
    logic [7:0] opcode;
    logic       cb_prefix;
    logic [1:0] tstate;
    logic [2:0] mcycle;
    logic       fetch;
    logic [4:0] int_ack;
    logic [7:0] int_vector;
    logic       ime;
    logic       halted;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_sequencer #(.INT_MCYCLES(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_rdata  (bus_rdata),
        .op_mcycles (op_mcycles),
        .cond_fail  (cond_fail),
        .ei_req     (ei_req),
        .di_req     (di_req),
        .halt_req   (halt_req),
        .int_pend   (int_pend),
        .opcode     (opcode),
        .cb_prefix  (cb_prefix),
        .tstate     (tstate),
        .mcycle     (mcycle),
        .fetch      (fetch),
        .int_ack    (int_ack),
        .int_vector (int_vector),
        .ime        (ime),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge inside T0 of the first fetch.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus_rdata = 8'h00; op_mcycles = 3'd1; cond_fail = 1'b0;
        ei_req = 1'b0; di_req = 1'b0; halt_req = 1'b0; int_pend = 5'b0;
        wait_clks(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (tstate !== 2'd0) $display("FAIL rst_tstate got %0d want 0", tstate); else n_pass++;
        n_checks++; if (mcycle !== 3'd0) $display("FAIL rst_mcycle got %0d want 0", mcycle); else n_pass++;
        n_checks++; if (opcode !== 8'h00) $display("FAIL rst_opcode got %h want 00", opcode); else n_pass++;
        n_checks++; if (fetch !== 1'b1) $display("FAIL rst_fetch got %b want 1", fetch); else n_pass++;
        n_checks++; if ({cb_prefix, ime, halted} !== 3'b000) $display("FAIL rst_flags got %b want 000", {cb_prefix, ime, halted}); else n_pass++;
        n_checks++; if (int_ack !== 5'b0) $display("FAIL rst_int_ack got %b want 00000", int_ack); else n_pass++;
        n_checks++; if (int_vector !== 8'h00) $display("FAIL rst_int_vector got %h want 00", int_vector); else n_pass++;
    endtask

    task automatic test_nop_stream();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (tstate !== 2'(i % 4)) $display("FAIL nop_tstate[%0d] got %0d want %0d", i, tstate, i % 4); else n_pass++;
            n_checks++; if (fetch !== 1'b1) $display("FAIL nop_fetch[%0d] got %b want 1", i, fetch); else n_pass++;
            n_checks++; if (mcycle !== 3'd0) $display("FAIL nop_mcycle[%0d] got %0d want 0", i, mcycle); else n_pass++;
            wait_clks(1);
        end
        n_checks++; if (opcode !== 8'h00) $display("FAIL nop_opcode got %h want 00", opcode); else n_pass++;
        bus_rdata = 8'h12;
        wait_clks(4);
        n_checks++; if (opcode !== 8'h12) $display("FAIL nop_latch got %h want 12", opcode); else n_pass++;
        bus_rdata = 8'h00;
    endtask

    task automatic test_cb_prefix();
        do_reset();
        bus_rdata = 8'hCB; op_mcycles = 3'd2;
        wait_clks(4);
        n_checks++; if ({fetch, mcycle} !== {1'b1, 3'd1}) $display("FAIL cb_fetch2 got fetch=%b mcycle=%0d want fetch=1 mcycle=1", fetch, mcycle); else n_pass++;
        n_checks++; if (opcode !== 8'hCB) $display("FAIL cb_first_byte got %h want cb", opcode); else n_pass++;
        bus_rdata = 8'h37;
        wait_clks(4);
        n_checks++; if ({cb_prefix, opcode} !== {1'b1, 8'h37}) $display("FAIL cb_latch got cb=%b op=%h want cb=1 op=37", cb_prefix, opcode); else n_pass++;
        n_checks++; if ({fetch, mcycle} !== {1'b0, 3'd2}) $display("FAIL cb_exec got fetch=%b mcycle=%0d want fetch=0 mcycle=2", fetch, mcycle); else n_pass++;
        bus_rdata = 8'h00;
        wait_clks(4);
        n_checks++; if ({fetch, mcycle} !== {1'b1, 3'd0}) $display("FAIL cb_refetch got fetch=%b mcycle=%0d want fetch=1 mcycle=0", fetch, mcycle); else n_pass++;
        op_mcycles = 3'd1;
        wait_clks(4);
        n_checks++; if (cb_prefix !== 1'b0) $display("FAIL cb_clear got %b want 0", cb_prefix); else n_pass++;
    endtask

    task automatic test_cond_fail();
        do_reset();
        bus_rdata = 8'hC2; op_mcycles = 3'd4;
        wait_clks(4);
        n_checks++; if ({fetch, mcycle, opcode} !== {1'b0, 3'd1, 8'hC2}) $display("FAIL jpcc_exec got fetch=%b mcycle=%0d op=%h want 0 1 c2", fetch, mcycle, opcode); else n_pass++;
        cond_fail = 1'b1;
        wait_clks(4);
        cond_fail = 1'b0;
        n_checks++; if ({fetch, mcycle} !== {1'b1, 3'd0}) $display("FAIL jpcc_abort got fetch=%b mcycle=%0d want fetch=1 mcycle=0", fetch, mcycle); else n_pass++;
        // Full-length 3 M-cycle instruction for contrast.
        bus_rdata = 8'h01; op_mcycles = 3'd3;
        wait_clks(4);
        n_checks++; if (mcycle !== 3'd1) $display("FAIL long_m1 got %0d want 1", mcycle); else n_pass++;
        wait_clks(4);
        n_checks++; if ({fetch, mcycle} !== {1'b0, 3'd2}) $display("FAIL long_m2 got fetch=%b mcycle=%0d want 0 2", fetch, mcycle); else n_pass++;
        wait_clks(4);
        n_checks++; if ({fetch, mcycle} !== {1'b1, 3'd0}) $display("FAIL long_end got fetch=%b mcycle=%0d want 1 0", fetch, mcycle); else n_pass++;
        bus_rdata = 8'h00; op_mcycles = 3'd1;
    endtask

    task automatic test_int_dispatch();
        do_reset();
        bus_rdata = 8'hFB; ei_req = 1'b1;
        wait_clks(4);
        ei_req = 1'b0; bus_rdata = 8'h00;
        n_checks++; if (ime !== 1'b0) $display("FAIL ei_delay got ime=%b want 0", ime); else n_pass++;
        wait_clks(4);
        n_checks++; if (ime !== 1'b1) $display("FAIL ei_effect got ime=%b want 1", ime); else n_pass++;
        int_pend = 5'b10100;
        wait_clks(4);
        n_checks++; if ({fetch, mcycle, ime} !== {1'b0, 3'd0, 1'b0}) $display("FAIL int_entry got fetch=%b mcycle=%0d ime=%b want 0 0 0", fetch, mcycle, ime); else n_pass++;
        int_pend = 5'b00011;
        wait_clks(16);
        n_checks++; if (mcycle !== 3'd4) $display("FAIL int_last_m got %0d want 4", mcycle); else n_pass++;
        n_checks++; if (int_ack !== 5'b00100) $display("FAIL int_ack got %b want 00100", int_ack); else n_pass++;
        n_checks++; if (int_vector !== 8'h50) $display("FAIL int_vector got %h want 50", int_vector); else n_pass++;
        wait_clks(1);
        n_checks++; if (int_ack !== 5'b0) $display("FAIL int_ack_pulse got %b want 00000", int_ack); else n_pass++;
        wait_clks(3);
        n_checks++; if ({fetch, mcycle, int_vector} !== {1'b1, 3'd0, 8'h50}) $display("FAIL int_exit got fetch=%b mcycle=%0d vec=%h want 1 0 50", fetch, mcycle, int_vector); else n_pass++;
        int_pend = 5'b0;
    endtask

    task automatic test_ei_di();
        do_reset();
        int_pend = 5'b00001;
        bus_rdata = 8'hFB; ei_req = 1'b1;
        wait_clks(4);
        ei_req = 1'b0; bus_rdata = 8'h00;
        n_checks++; if (fetch !== 1'b1) $display("FAIL ei_no_dispatch got fetch=%b want 1", fetch); else n_pass++;
        wait_clks(4);
        n_checks++; if ({fetch, ime} !== 2'b00) $display("FAIL ei_nop_dispatch got fetch=%b ime=%b want 0 0", fetch, ime); else n_pass++;
        wait_clks(16);
        n_checks++; if ({int_ack, int_vector} !== {5'b00001, 8'h40}) $display("FAIL vblank_ack got ack=%b vec=%h want 00001 40", int_ack, int_vector); else n_pass++;
        wait_clks(4);
        // EI immediately followed by DI must never enable.
        do_reset();
        int_pend = 5'b00001;
        bus_rdata = 8'hFB; ei_req = 1'b1;
        wait_clks(4);
        ei_req = 1'b0; bus_rdata = 8'hF3; di_req = 1'b1;
        wait_clks(4);
        di_req = 1'b0; bus_rdata = 8'h00;
        n_checks++; if ({fetch, ime} !== 2'b10) $display("FAIL di_cancel got fetch=%b ime=%b want 1 0", fetch, ime); else n_pass++;
        wait_clks(4);
        n_checks++; if ({fetch, ime} !== 2'b10) $display("FAIL di_stays got fetch=%b ime=%b want 1 0", fetch, ime); else n_pass++;
        int_pend = 5'b0;
    endtask

    task automatic test_halt();
        logic saw_ack;
        do_reset();
        bus_rdata = 8'h76; halt_req = 1'b1;
        wait_clks(4);
        halt_req = 1'b0; bus_rdata = 8'h00;
        n_checks++; if ({halted, fetch, mcycle} !== {1'b1, 1'b0, 3'd0}) $display("FAIL halt_entry got h=%b f=%b m=%0d want 1 0 0", halted, fetch, mcycle); else n_pass++;
        wait_clks(2);
        n_checks++; if ({tstate, halted} !== {2'd2, 1'b1}) $display("FAIL halt_run got t=%0d h=%b want 2 1", tstate, halted); else n_pass++;
        wait_clks(6);
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_hold got %b want 1", halted); else n_pass++;
        int_pend = 5'b00010;
        saw_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int_ack !== 5'b0) saw_ack = 1'b1;
            wait_clks(1);
        end
        n_checks++; if ({halted, fetch, mcycle} !== {1'b0, 1'b1, 3'd0}) $display("FAIL halt_exit got h=%b f=%b m=%0d want 0 1 0", halted, fetch, mcycle); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (int_ack !== 5'b0) saw_ack = 1'b1;
            wait_clks(1);
        end
        n_checks++; if (saw_ack !== 1'b0) $display("FAIL halt_no_ack got %b want 0", saw_ack); else n_pass++;
        int_pend = 5'b0;
    endtask

    task automatic test_reset_mid_int();
        do_reset();
        bus_rdata = 8'hFB; ei_req = 1'b1;
        wait_clks(4);
        ei_req = 1'b0; bus_rdata = 8'h00;
        wait_clks(4);
        int_pend = 5'b00100;
        wait_clks(24);
        n_checks++; if ({fetch, int_vector} !== {1'b1, 8'h50}) $display("FAIL rmi_first got f=%b vec=%h want 1 50", fetch, int_vector); else n_pass++;
        int_pend = 5'b00001;
        bus_rdata = 8'hFB; ei_req = 1'b1;
        wait_clks(4);
        ei_req = 1'b0; bus_rdata = 8'h00;
        wait_clks(4);
        wait_clks(14);
        n_checks++; if ({fetch, mcycle, tstate} !== {1'b0, 3'd3, 2'd2}) $display("FAIL rmi_pos got f=%b m=%0d t=%0d want 0 3 2", fetch, mcycle, tstate); else n_pass++;
        rst = 1'b1;
        wait_clks(1);
        n_checks++; if ({tstate, mcycle, opcode} !== {2'd0, 3'd0, 8'h00}) $display("FAIL rmi_timing got t=%0d m=%0d op=%h want 0 0 00", tstate, mcycle, opcode); else n_pass++;
        n_checks++; if ({fetch, cb_prefix, ime, halted} !== 4'b1000) $display("FAIL rmi_flags got %b want 1000", {fetch, cb_prefix, ime, halted}); else n_pass++;
        n_checks++; if ({int_ack, int_vector} !== {5'b0, 8'h00}) $display("FAIL rmi_irq got ack=%b vec=%h want 00000 00", int_ack, int_vector); else n_pass++;
        wait_clks(1);
        n_checks++; if ({int_ack, tstate} !== {5'b0, 2'd0}) $display("FAIL rmi_hold got ack=%b t=%0d want 00000 0", int_ack, tstate); else n_pass++;
        rst = 1'b0; int_pend = 5'b0;
        wait_clks(4);
        n_checks++; if ({fetch, ime} !== 2'b10) $display("FAIL rmi_after got f=%b ime=%b want 1 0", fetch, ime); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_cb_prefix();
        test_cond_fail();
        test_int_dispatch();
        test_ei_di();
        test_halt();
        test_reset_mid_int();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter INT_MCYCLES, default 5, meaning M-cycles spent in interrupt dispatch.
REQ-002 SHALL have port clk, in, 1, system clock; the only clock.
REQ-003 SHALL have port rst, in, 1, synchronous reset, active-high.
REQ-004 SHALL have port bus_rdata, in, 8, memory read data, valid at T3 of a fetch M-cycle.
REQ-005 SHALL have port op_mcycles, in, 3, M-cycle count of the latched opcode from the decode lookup (1..6; 0 is treated as 1).
REQ-006 SHALL have port cond_fail, in, 1, condition-not-met from the ALU flags; sampled at T3.
REQ-007 SHALL have ports ei_req, di_req and halt_req, in, 1 each, decode strobes; sampled at T3 of the last M-cycle.
REQ-008 SHALL have port int_pend, in, 5, IE AND IF, bit 0 = VBlank.
REQ-009 SHALL have port opcode, out, 8, latched opcode.
REQ-010 SHALL have port cb_prefix, out, 1, meaning the latched opcode is from the CB table.
REQ-011 SHALL have ports tstate (out, 2) and mcycle (out, 3), the current T-state and M-cycle index within the instruction.
REQ-012 SHALL have port fetch, out, 1, meaning the current M-cycle is an opcode fetch.
REQ-013 SHALL have ports int_ack (out, 5, one-hot), int_vector (out, 8), ime (out, 1) and halted (out, 1).

Function
REQ-014 tstate SHALL count 0,1,2,3 and wrap every clk; all state and mcycle changes SHALL occur only on the clk edge ending T3.
REQ-015 States SHALL be FETCH, CB_FETCH, EXEC, HALT and INT.
REQ-016 FETCH SHALL hold fetch=1 and mcycle=0, and SHALL latch opcode<=bus_rdata at the end of T3.
REQ-017 When the latched byte is 0xCB, FETCH SHALL go to CB_FETCH (fetch=1, mcycle=1) and SHALL latch the next byte with cb_prefix=1.
REQ-018 Otherwise FETCH SHALL clear cb_prefix.
REQ-019 EXEC SHALL advance mcycle each M-cycle until mcycle+1 = op_mcycles; that M-cycle is the last one.
REQ-020 If op_mcycles=1, the fetch M-cycle itself SHALL be the last one (fetch/execute overlap).
REQ-021 cond_fail=1 at T3 SHALL make the current M-cycle the last one.
REQ-022 An instruction boundary SHALL be the end of a last M-cycle; the priority there SHALL be: interrupt dispatch, then halt_req, then FETCH.
REQ-023 Interrupt dispatch SHALL occur when ime=1 and int_pend!=0.
REQ-024 halt_req SHALL enter HALT.
REQ-025 INT SHALL last INT_MCYCLES M-cycles with mcycle counting 0..INT_MCYCLES-1, and SHALL clear ime on entry.
REQ-026 On entry to INT, the lowest set int_pend bit n SHALL be frozen.
REQ-027 In the final INT M-cycle at T0, int_ack SHALL pulse bit n for exactly one clk and int_vector SHALL be 0x40+8n; the state then returns to FETCH.
REQ-028 int_vector SHALL hold its value until the next dispatch.
REQ-029 HALT SHALL assert halted=1, SHALL keep tstate running and SHALL hold mcycle=0.
REQ-030 HALT SHALL exit at the end of the M-cycle where int_pend!=0: to INT if ime=1, else to FETCH. The HALT bug is not modelled.
REQ-031 di_req SHALL clear ime immediately at the boundary.
REQ-032 ei_req SHALL set ime only at the end of the following instruction's boundary, so no dispatch occurs at the EI boundary itself.
REQ-033 A di_req in the instruction after EI SHALL cancel the pending enable.
REQ-034 int_pend changing mid-INT SHALL NOT alter the frozen n.
REQ-035 If int_pend drops to 0 during INT, dispatch SHALL still complete with the frozen n.

Reset
REQ-036 While rst=1 at a clk edge, the state SHALL become FETCH and tstate, mcycle and opcode SHALL become 0.
REQ-037 While rst=1, cb_prefix, ime, halted and int_ack SHALL become 0, int_vector SHALL become 0x00, and the pending-EI flag SHALL clear.
REQ-038 Reset asserted mid-instruction, in HALT or in INT SHALL abort immediately with no int_ack pulse.
REQ-039 The first fetch T0 SHALL be the cycle after rst falls.

Structure
REQ-040 State encodings, the CB prefix constant 0xCB, vector base 0x40 and the IRQ bit positions SHALL live in the shared CPU package, also used by the decode lookup.
REQ-041 One sub-module, irq_prio (5-bit lowest-set-bit priority encoder giving index and one-hot), is natural; all else SHALL be inline.

Verification
REQ-042 Verify: rst then NOP stream (bus_rdata=0x00, op_mcycles=1) -> fetch=1 continuously, mcycle=0, tstate wraps 0..3, opcode=0x00.
REQ-043 Verify: bytes 0xCB,0x37 with op_mcycles=2 -> cb_prefix=1 and opcode=0x37 after the second fetch; one EXEC M-cycle (mcycle=2); then FETCH.
REQ-044 Verify: JP cc (0xC2), op_mcycles=4, cond_fail=1 at the first EXEC T3 -> FETCH starts after 2 M-cycles (8 clks), not 16.
REQ-045 Verify: ime=1 with int_pend=5'b10100 at a boundary -> INT for 20 clks, int_ack=5'b00100 for one clk, int_vector=0x50, ime=0.
REQ-046 Verify: EI, then NOP with int_pend=1 -> no dispatch after EI; dispatch after the NOP with vector 0x40. EI followed by DI -> no dispatch.
REQ-047 Verify: HALT with ime=0, int_pend rises -> halted falls at the end of that M-cycle and FETCH follows with no int_ack; rst asserted mid-INT -> all outputs reset.
